instr_receive: RTL



---
 rtl/instr_receive.sv | 98 +++++++++
 1 files changed

// File: rtl/instr_receive.sv
// rtl/instr_receive.sv - receive side of the instruction transfer link.
// Drives syn, captures the acked stream into a buffer and serves registered reads.
module instr_receive #(
  parameter int IWIDTH  = 32,
  parameter int DEPTH   = 5,
  parameter int AWIDTH  = 3,
  parameter int TIMEOUT = 16
) (
  input  logic              r_clk,
  input  logic              r_rst,
  output logic              r_o_syn,
  input  logic [IWIDTH-1:0] r_i_instr,
  input  logic              r_i_ack,
  input  logic              r_i_last,
  output logic              r_o_ready,
  output logic              r_o_err,
  output logic [AWIDTH-1:0] r_o_count,
  input  logic [AWIDTH-1:0] r_i_raddr,
  output logic [IWIDTH-1:0] r_o_rdata,
  output logic              r_o_rvalid
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  // One spare count bit so a full load of 2^AWIDTH words is still representable.
  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] LAST_C  = (AWIDTH+1)'(DEPTH - 1);
  localparam logic [7:0]      TLIM    = 8'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [AWIDTH:0]   count, count_nxt;
  logic [7:0]        tcnt, tcnt_nxt;
  logic              wr_en;
  logic [IWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tcnt_nxt  = tcnt;
    wr_en     = 1'b0;
    case (state)
      IDLE: state_nxt = LOAD;
      LOAD: begin
        if (r_i_ack) begin
          wr_en    = 1'b1;
          tcnt_nxt = 8'd0;
          if (count != DEPTH_C)
            count_nxt = count + 1'b1;
          if (r_i_last)
            state_nxt = (count == LAST_C) ? DONE : ERR;
          else if (count == LAST_C)
            state_nxt = ERR;
        end else begin
          tcnt_nxt = tcnt + 8'd1;
          if (tcnt == TLIM)
            state_nxt = ERR;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state      <= IDLE;
      count      <= '0;
      tcnt       <= 8'd0;
      r_o_syn    <= 1'b0;
      r_o_ready  <= 1'b0;
      r_o_err    <= 1'b0;
      r_o_rdata  <= '0;
      r_o_rvalid <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      tcnt      <= tcnt_nxt;
      r_o_syn   <= (state_nxt == LOAD);
      r_o_ready <= (state_nxt == DONE);
      r_o_err   <= (state_nxt == ERR);
      if (r_o_ready && ({1'b0, r_i_raddr} < DEPTH_C)) begin
        r_o_rdata  <= mem[r_i_raddr];
        r_o_rvalid <= 1'b1;
      end else begin
        r_o_rdata  <= '0;
        r_o_rvalid <= 1'b0;
      end
    end
  end

  // Buffer is never cleared; reads are gated by r_o_ready instead.
  always_ff @(posedge r_clk) begin
    if (wr_en && !r_rst)
      mem[count[AWIDTH-1:0]] <= r_i_instr;
  end

  assign r_o_count = count[AWIDTH-1:0];

endmodule
